// File: rtl/vram_writer.sv
// CPU-side owner of the 20x15-cell video memory: memory-mapped CPU port, whole-screen
// fill engine and a registered read port for the VGA scan-out block.
module vram_writer #(
    parameter logic [31:0] BASE     = 32'h0000_2000,
    parameter int          CELLS    = 300,
    parameter logic [31:0] CTRL_OFS = 32'h0000_04C0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_we,
    input  logic        cpu_re,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ready,
    output logic [31:0] cpu_rdata,
    output logic        cpu_rvalid,
    input  logic [8:0]  vaddr,
    output logic [31:0] vdata,
    output logic        busy
);

    localparam logic [31:0] CELL_BYTES = 32'(4 * CELLS);
    localparam logic [8:0]  LAST_IDX   = 9'(CELLS - 1);

    typedef enum logic {IDLE, FILL} state_t;
    typedef enum logic [1:0] {SEL_NONE, SEL_CELL, SEL_CTRL} rsel_t;

    state_t      state_q, state_d;
    logic [8:0]  fill_idx_q, fill_idx_d;
    logic [31:0] fill_val_q, fill_val_d;
    logic        fill_we;

    rsel_t       rsel_q;
    logic [31:0] ctrl_word_q;
    logic        rvalid_q;
    logic        vga_ok_q;

    // Address decode; the subtraction wraps so addresses below BASE become misses.
    logic [31:0] off;
    logic        cell_hit;
    logic        ctrl_hit;
    logic [8:0]  cpu_idx;

    assign off      = cpu_addr - BASE;
    assign cell_hit = (off < CELL_BYTES);
    assign ctrl_hit = (off == CTRL_OFS);
    assign cpu_idx  = off[10:2];

    assign busy      = (state_q == FILL);
    assign cpu_ready = ~busy;

    logic cpu_wr_cell;
    logic rd_acc;

    assign cpu_wr_cell = cpu_ready & cpu_we & cell_hit;
    assign rd_acc      = cpu_ready & cpu_re & ~cpu_we;

    // Shared write port: fill and CPU are mutually exclusive because busy stalls the CPU.
    logic        wr_en;
    logic [8:0]  wr_addr;
    logic [31:0] wr_data;

    assign wr_en   = ~reset & (fill_we | cpu_wr_cell);
    assign wr_addr = fill_we ? fill_idx_q : cpu_idx;
    assign wr_data = fill_we ? fill_val_q : cpu_wdata;

    // Read port 0 serves the CPU, port 1 serves the VGA block.
    logic [1:0][8:0]  rd_addr;
    logic [1:0]       rd_en;
    logic [1:0][31:0] rd_data;
    logic             vga_ok;

    assign vga_ok     = (vaddr <= LAST_IDX);
    assign rd_addr[0] = cpu_idx;
    assign rd_en[0]   = rd_acc & cell_hit;
    assign rd_addr[1] = vaddr;
    assign rd_en[1]   = vga_ok;

    // Two copies written in lockstep give two independent read-before-write read ports.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ram
            logic [31:0] mem [0:CELLS-1];
            logic [31:0] rd_q;

            always_ff @(posedge clk) begin
                if (wr_en) begin
                    mem[wr_addr] <= wr_data;
                end
                if (rd_en[gi]) begin
                    rd_q <= mem[rd_addr[gi]];
                end
            end

            assign rd_data[gi] = rd_q;
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        fill_idx_d = fill_idx_q;
        fill_val_d = fill_val_q;
        fill_we    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_we && ctrl_hit) begin
                    state_d    = FILL;
                    fill_idx_d = 9'd0;
                    fill_val_d = cpu_wdata;
                end
            end
            FILL: begin
                fill_we = 1'b1;
                if (fill_idx_q == LAST_IDX) begin
                    state_d    = IDLE;
                    fill_idx_d = 9'd0;
                end else begin
                    fill_idx_d = fill_idx_q + 9'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            fill_idx_q <= 9'd0;
            fill_val_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            fill_idx_q <= fill_idx_d;
            fill_val_q <= fill_val_d;
        end
    end

    // Read-side bookkeeping; the selector holds so cpu_rdata stays stable between reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsel_q      <= SEL_NONE;
            ctrl_word_q <= 32'd0;
            rvalid_q    <= 1'b0;
            vga_ok_q    <= 1'b0;
        end else begin
            rvalid_q <= rd_acc;
            vga_ok_q <= vga_ok;
            if (rd_acc) begin
                if (cell_hit) begin
                    rsel_q <= SEL_CELL;
                end else if (ctrl_hit) begin
                    rsel_q <= SEL_CTRL;
                end else begin
                    rsel_q <= SEL_NONE;
                end
                ctrl_word_q <= {22'd0, fill_idx_q, busy};
            end
        end
    end

    always_comb begin
        cpu_rdata = 32'd0;
        case (rsel_q)
            SEL_CELL: cpu_rdata = rd_data[0];
            SEL_CTRL: cpu_rdata = ctrl_word_q;
            default:  cpu_rdata = 32'd0;
        endcase
    end

    assign cpu_rvalid = rvalid_q;
    assign vdata      = vga_ok_q ? rd_data[1] : 32'd0;

endmodule
